// File: rtl/square_jump_ctrl.sv
// Per-frame controller for the Square player sprite: jump physics, single-obstacle
// collision, lives and game-over. State advances once per video frame.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for start after reset
// S_RUN       | playing; collisions checked each frame
// S_HIT_BLINK | invulnerable after a hit; sprite blinks, physics keeps running
// S_GAME_OVER | lives exhausted; physics frozen until start
module square_jump_ctrl #(
    parameter int X_IDLE       = 160,
    parameter int SIZE         = 16,
    parameter int JUMP_V       = 12,
    parameter int GRAV         = 1,
    parameter int MAX_H        = 400,
    parameter int OBST_W       = 16,
    parameter int OBST_H       = 24,
    parameter int LIVES        = 3,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_x_cord,
    input  logic [9:0] i_y_cord,
    input  logic       start,
    input  logic       jump_btn,
    input  logic       obst_valid,
    input  logic [9:0] obst_x,
    output logic [9:0] height,
    output logic       jumping,
    output logic       hit,
    output logic       show,
    output logic [2:0] lives,
    output logic       game_over
);

    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic signed [10:0] MAX_H_S = 11'(MAX_H);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT_BLINK, S_GAME_OVER} state_t;

    state_t            state_q, state_d;
    logic              fr_q, fr_dly_q, tick;
    logic              jb_q, jpend_q, jpend_d;
    logic [9:0]        height_q, height_d;
    logic signed [7:0] vel_q, vel_d;
    logic              jumping_q, jumping_d;
    logic [2:0]        lives_q, lives_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              in_play, launch, coll;
    logic [10:0]       obst_l, obst_r;
    logic signed [10:0] sum;

    // Edge of the (1,1) marker, so a coordinate held for several clocks ticks once.
    assign tick    = fr_q & ~fr_dly_q;
    assign in_play = (state_q == S_RUN) || (state_q == S_HIT_BLINK);
    assign launch  = tick & in_play & jpend_q & ~jumping_q;

    assign obst_l = {1'b0, obst_x};
    assign obst_r = obst_l + 11'(OBST_W);
    assign coll   = obst_valid && (obst_r > 11'(X_IDLE - SIZE)) &&
                    (obst_l < 11'(X_IDLE + SIZE)) && ({1'b0, height_q} < 11'(OBST_H));
    assign sum    = $signed({1'b0, height_q}) + $signed({{3{vel_q[7]}}, vel_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fr_q      <= 1'b0;
            fr_dly_q  <= 1'b0;
            jb_q      <= 1'b0;
            jpend_q   <= 1'b0;
            height_q  <= '0;
            vel_q     <= '0;
            jumping_q <= 1'b0;
            lives_q   <= 3'(LIVES);
            bcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            fr_q      <= (i_x_cord == 10'd1) && (i_y_cord == 10'd1);
            fr_dly_q  <= fr_q;
            jb_q      <= jump_btn;
            jpend_q   <= jpend_d;
            height_q  <= height_d;
            vel_q     <= vel_d;
            jumping_q <= jumping_d;
            lives_q   <= lives_d;
            bcnt_q    <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_IDLE:      if (start) state_d = S_RUN;
                S_RUN:       if (coll) state_d = (lives_q == 3'd1) ? S_GAME_OVER : S_HIT_BLINK;
                S_HIT_BLINK: if (bcnt_q == BW'(1)) state_d = S_RUN;
                S_GAME_OVER: if (start) state_d = S_RUN;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        height_d  = height_q;
        vel_d     = vel_q;
        jumping_d = jumping_q;
        lives_d   = lives_q;
        bcnt_d    = bcnt_q;
        jpend_d   = in_play & ((jpend_q & ~launch) | (jump_btn & ~jb_q));

        if (launch) begin
            height_d  = 10'(JUMP_V);
            vel_d     = 8'(JUMP_V - GRAV);
            jumping_d = 1'b1;
        end else if (tick && in_play && jumping_q) begin
            // Landing tick never relaunches; a pending jump waits for the next frame.
            if (sum <= 11'sd0) begin
                height_d  = '0;
                vel_d     = '0;
                jumping_d = 1'b0;
            end else begin
                height_d = (sum > MAX_H_S) ? 10'(MAX_H) : sum[9:0];
                vel_d    = vel_q - 8'(GRAV);
            end
        end

        if (tick) begin
            case (state_q)
                S_IDLE: if (start) lives_d = 3'(LIVES);
                S_RUN: begin
                    if (coll) begin
                        lives_d = lives_q - 3'd1;
                        if (lives_q != 3'd1) bcnt_d = BW'(BLINK_FRAMES);
                    end
                end
                S_HIT_BLINK: bcnt_d = bcnt_q - BW'(1);
                S_GAME_OVER: begin
                    if (start) begin
                        lives_d   = 3'(LIVES);
                        height_d  = '0;
                        vel_d     = '0;
                        jumping_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hit       = 1'b0;
        show      = 1'b1;
        game_over = 1'b0;
        case (state_q)
            S_HIT_BLINK: begin
                hit  = 1'b1;
                show = ~bcnt_q[2];
            end
            S_GAME_OVER: begin
                hit       = 1'b1;
                game_over = 1'b1;
            end
            default: ;
        endcase
    end

    assign height  = height_q;
    assign jumping = jumping_q;
    assign lives   = lives_q;

endmodule

// File: tb/tb_square_jump_ctrl.sv
// Self-checking bench for square_jump_ctrl: a frame-level reference model pushes
// expected outputs per frame; each frame's outputs are popped and compared.
module tb_square_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x_cord = '0;
    logic [9:0] y_cord = '0;
    logic       start = 1'b0;
    logic       jump_btn = 1'b0;
    logic       obst_valid = 1'b0;
    logic [9:0] obst_x = '0;
    logic [9:0] height;
    logic       jumping, hit, show, game_over;
    logic [2:0] lives;

    square_jump_ctrl dut (
        .clk(clk), .rst(rst), .i_x_cord(x_cord), .i_y_cord(y_cord),
        .start(start), .jump_btn(jump_btn), .obst_valid(obst_valid), .obst_x(obst_x),
        .height(height), .jumping(jumping), .hit(hit), .show(show),
        .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        bit j;
        bit hit;
        bit show;
        int lives;
        bit go;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: 0 idle, 1 run, 2 blink, 3 game over
    int m_st, m_h, m_v, m_lives, m_bcnt;
    bit m_jmp, m_jpend;

    task model_reset();
        m_st = 0; m_h = 0; m_v = 0; m_lives = 3; m_bcnt = 0; m_jmp = 0; m_jpend = 0;
    endtask

    task model_tick();
        int s;
        bit coll, inplay;
        exp_t e;
        inplay = (m_st == 1) || (m_st == 2);
        coll = (m_st == 1) && obst_valid && (int'(obst_x) + 16 > 144) &&
               (int'(obst_x) < 176) && (m_h < 24);
        if (inplay) begin
            if (m_jpend && !m_jmp) begin
                m_h = 12; m_v = 11; m_jmp = 1; m_jpend = 0;
            end else if (m_jmp) begin
                s = m_h + m_v;
                if (s <= 0) begin
                    m_h = 0; m_v = 0; m_jmp = 0;
                end else begin
                    m_h = (s > 400) ? 400 : s;
                    m_v = m_v - 1;
                end
            end
        end
        case (m_st)
            0: if (start) begin m_st = 1; m_lives = 3; end
            1: if (coll) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_st = 3;
                else begin m_st = 2; m_bcnt = 32; end
            end
            2: begin
                if (m_bcnt == 1) m_st = 1;
                m_bcnt = m_bcnt - 1;
            end
            default: if (start) begin
                m_st = 1; m_lives = 3; m_h = 0; m_v = 0; m_jmp = 0;
            end
        endcase
        if (!(m_st == 1 || m_st == 2)) m_jpend = 0;
        e.h     = m_h;
        e.j     = m_jmp;
        e.hit   = (m_st == 2) || (m_st == 3);
        e.show  = (m_st == 2) ? ((m_bcnt & 4) == 0) : 1'b1;
        e.lives = m_lives;
        e.go    = (m_st == 3);
        sb.push_back(e);
    endtask

    task press_jump();
        @(negedge clk); jump_btn = 1'b1;
        @(negedge clk); jump_btn = 1'b0;
        if (m_st == 1 || m_st == 2) m_jpend = 1;
    endtask

    // One video frame: (1,1) held for 'hold' clocks, then outputs checked against the model.
    task run_frame(input int hold);
        exp_t e;
        model_tick();
        @(negedge clk); x_cord = 10'd1; y_cord = 10'd1;
        repeat (hold) @(negedge clk);
        x_cord = 10'd5; y_cord = 10'd5;
        repeat (3) @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (height !== 10'(e.h)) $display("FAIL frame_height got %0d want %0d", height, e.h);
        else n_pass++;
        n_checks++;
        if (jumping !== e.j) $display("FAIL frame_jumping got %0b want %0b", jumping, e.j);
        else n_pass++;
        n_checks++;
        if (hit !== e.hit) $display("FAIL frame_hit got %0b want %0b", hit, e.hit);
        else n_pass++;
        n_checks++;
        if (show !== e.show) $display("FAIL frame_show got %0b want %0b", show, e.show);
        else n_pass++;
        n_checks++;
        if (lives !== 3'(e.lives)) $display("FAIL frame_lives got %0d want %0d", lives, e.lives);
        else n_pass++;
        n_checks++;
        if (game_over !== e.go) $display("FAIL frame_game_over got %0b want %0b", game_over, e.go);
        else n_pass++;
    endtask

    task test_reset();
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (height !== 10'd0) $display("FAIL rst_height got %0d want 0", height); else n_pass++;
        n_checks++; if (jumping !== 1'b0) $display("FAIL rst_jumping got %0b want 0", jumping); else n_pass++;
        n_checks++; if (hit !== 1'b0) $display("FAIL rst_hit got %0b want 0", hit); else n_pass++;
        n_checks++; if (show !== 1'b1) $display("FAIL rst_show got %0b want 1", show); else n_pass++;
        n_checks++; if (lives !== 3'd3) $display("FAIL rst_lives got %0d want 3", lives); else n_pass++;
        n_checks++; if (game_over !== 1'b0) $display("FAIL rst_game_over got %0b want 0", game_over); else n_pass++;
        rst = 1'b0;
        // Idle ignores jump and obstacle
        obst_x = 10'd150; obst_valid = 1'b1;
        press_jump();
        run_frame(2);
        obst_valid = 1'b0;
    endtask

    task test_tick();
        start = 1'b1;
        run_frame(5);
        start = 1'b0;
        n_checks++; if (lives !== 3'd3) $display("FAIL tick_start_lives got %0d want 3", lives); else n_pass++;
        press_jump();
        run_frame(5);
        n_checks++; if (height !== 10'd12) $display("FAIL tick_single got %0d want 12", height); else n_pass++;
    endtask

    task test_full_jump();
        int w;
        for (int t = 2; t <= 25; t++) begin
            run_frame(2);
            case (t)
                2:       w = 23;
                3:       w = 33;
                12, 13:  w = 78;
                25:      w = 0;
                default: w = -1;
            endcase
            if (w >= 0) begin
                n_checks++;
                if (height !== 10'(w)) $display("FAIL jump_tick%0d got %0d want %0d", t, height, w);
                else n_pass++;
            end
        end
        n_checks++; if (jumping !== 1'b0) $display("FAIL jump_landed got %0b want 0", jumping); else n_pass++;
    endtask

    task test_ground_collision();
        obst_x = 10'd150; obst_valid = 1'b1;
        run_frame(2);
        obst_valid = 1'b0;
        n_checks++; if (lives !== 3'd2) $display("FAIL gcoll_lives got %0d want 2", lives); else n_pass++;
        n_checks++; if (hit !== 1'b1) $display("FAIL gcoll_hit got %0b want 1", hit); else n_pass++;
        for (int i = 1; i <= 32; i++) begin
            run_frame(2);
            if (i == 31) begin
                n_checks++; if (hit !== 1'b1) $display("FAIL gcoll_blink31 got %0b want 1", hit); else n_pass++;
            end
        end
        n_checks++; if (hit !== 1'b0) $display("FAIL gcoll_end_hit got %0b want 0", hit); else n_pass++;
        n_checks++; if (show !== 1'b1) $display("FAIL gcoll_end_show got %0b want 1", show); else n_pass++;
    endtask

    task test_clearance();
        press_jump();
        repeat (3) run_frame(2);
        obst_x = 10'd150; obst_valid = 1'b1;
        run_frame(2);
        n_checks++; if (hit !== 1'b0) $display("FAIL clear_high got %0b want 0", hit); else n_pass++;
        obst_x = 10'd176;
        repeat (23) run_frame(2);
        n_checks++; if (lives !== 3'd2) $display("FAIL clear_right got %0d want 2", lives); else n_pass++;
        obst_x = 10'd129;
        run_frame(2);
        obst_valid = 1'b0;
        n_checks++; if (hit !== 1'b1) $display("FAIL clear_left_edge got %0b want 1", hit); else n_pass++;
        repeat (32) run_frame(2);
    endtask

    task test_game_over();
        // Last life lost on the same tick a jump launches
        press_jump();
        obst_x = 10'd150; obst_valid = 1'b1;
        run_frame(2);
        obst_valid = 1'b0;
        n_checks++; if (game_over !== 1'b1) $display("FAIL go_flag got %0b want 1", game_over); else n_pass++;
        n_checks++; if (height !== 10'd12) $display("FAIL go_launch_height got %0d want 12", height); else n_pass++;
        press_jump();
        repeat (3) run_frame(2);
        n_checks++; if (height !== 10'd12) $display("FAIL go_frozen got %0d want 12", height); else n_pass++;
        start = 1'b1;
        run_frame(2);
        start = 1'b0;
        n_checks++; if (height !== 10'd0) $display("FAIL go_restart_height got %0d want 0", height); else n_pass++;
        n_checks++; if (lives !== 3'd3) $display("FAIL go_restart_lives got %0d want 3", lives); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            obst_valid = 1'b1;
            run_frame(2);
            obst_valid = 1'b0;
            if (k < 2) repeat (32) run_frame(2);
        end
        n_checks++; if (lives !== 3'd0) $display("FAIL go_three_hits got %0d want 0", lives); else n_pass++;
        start = 1'b1;
        run_frame(2);
        start = 1'b0;
    endtask

    task test_reset_mid_jump();
        press_jump();
        repeat (6) run_frame(2);
        n_checks++; if (height !== 10'd57) $display("FAIL midjump_height got %0d want 57", height); else n_pass++;
        @(negedge clk);
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (height !== 10'd0) $display("FAIL async_height got %0d want 0", height); else n_pass++;
        n_checks++; if (jumping !== 1'b0) $display("FAIL async_jumping got %0b want 0", jumping); else n_pass++;
        n_checks++; if (show !== 1'b1) $display("FAIL async_show got %0b want 1", show); else n_pass++;
        n_checks++; if (lives !== 3'd3) $display("FAIL async_lives got %0d want 3", lives); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        press_jump();
        run_frame(2);
        n_checks++; if (height !== 10'd0) $display("FAIL idle_after_rst got %0d want 0", height); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tick();
        test_full_jump();
        test_ground_collision();
        test_clearance();
        test_game_over();
        test_reset_mid_jump();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
